// File: rtl/bram_ring_reader.sv
// ============================================================================
// Module  : bram_ring_reader
// Purpose : Drains a BRAM word ring in order onto a valid/ready stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bram_ring_reader #(
  parameter int BRAM_DEPTH_WORDS = 16384,
  parameter int PREFETCH_DEPTH   = 4,
  parameter int OVERRUN_MARGIN   = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        flush,
  input  logic        clear_overrun,
  input  logic [13:0] write_address,
  output logic [15:0] bram_addr,
  input  logic [31:0] bram_dout,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic        bram_clk,
  output logic        bram_rst,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [13:0] read_address,
  output logic [14:0] words_available,
  output logic        overrun
);

  localparam int c_PW          = $clog2(PREFETCH_DEPTH);
  localparam int c_LAST_INT    = BRAM_DEPTH_WORDS - 1;
  localparam int c_OVR_TH_INT  = (BRAM_DEPTH_WORDS > OVERRUN_MARGIN) ?
                                 (BRAM_DEPTH_WORDS - OVERRUN_MARGIN) : 0;

  localparam logic [14:0]     c_DEPTH      = BRAM_DEPTH_WORDS[14:0];
  localparam logic [13:0]     c_LAST       = c_LAST_INT[13:0];
  localparam logic [14:0]     c_OVR_TH     = c_OVR_TH_INT[14:0];
  localparam logic [c_PW+1:0] c_FIFO_DEPTH = PREFETCH_DEPTH[c_PW+1:0];
  localparam logic [c_PW-1:0] c_PTR_ONE    = c_PW'(1);
  localparam logic [c_PW:0]   c_CNT_ONE    = (c_PW + 1)'(1);

  logic [13:0]     r_wr_q;
  logic [13:0]     r_rd_ptr;
  logic [14:0]     r_words_avail;
  logic            r_bram_en;
  logic [15:0]     r_bram_addr;
  logic            r_overrun;

  logic [31:0]     r_fifo_mem [PREFETCH_DEPTH];
  logic [c_PW-1:0] r_fifo_wptr;
  logic [c_PW-1:0] r_fifo_rptr;
  logic [c_PW:0]   r_fifo_count;

  logic [14:0]     w_diff;
  logic [14:0]     w_gap;
  logic [c_PW+1:0] w_credit_used;
  logic [13:0]     w_rd_ptr_inc;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_nempty;
  logic            w_ovr_set;

  // Ring occupancy without assuming a power-of-two depth.
  assign w_diff = {1'b0, r_wr_q} - {1'b0, r_rd_ptr};
  assign w_gap  = (r_wr_q >= r_rd_ptr) ? w_diff : (w_diff + c_DEPTH);

  // Credits: buffered words plus the read whose data lands at the next edge.
  assign w_credit_used = {1'b0, r_fifo_count} + {{(c_PW + 1){1'b0}}, r_bram_en};
  assign w_issue       = enable & ~flush & (w_gap != 15'd0) &
                         (w_credit_used < c_FIFO_DEPTH);

  assign w_rd_ptr_inc  = (r_rd_ptr >= c_LAST) ? 14'd0 : (r_rd_ptr + 14'd1);
  assign w_fifo_nempty = (r_fifo_count != '0);
  assign w_push        = r_bram_en & ~flush;
  assign w_pop         = w_fifo_nempty & m_tready & ~flush;
  assign w_ovr_set     = (w_gap >= c_OVR_TH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_q        <= 14'd0;
      r_rd_ptr      <= 14'd0;
      r_words_avail <= 15'd0;
      r_bram_en     <= 1'b0;
      r_bram_addr   <= 16'd0;
      r_overrun     <= 1'b0;
    end else begin
      r_wr_q        <= write_address;
      r_words_avail <= w_gap;
      r_bram_en     <= w_issue;
      if (flush) begin
        r_rd_ptr <= r_wr_q;
      end else if (w_issue) begin
        r_rd_ptr    <= w_rd_ptr_inc;
        r_bram_addr <= {r_rd_ptr, 2'b00};
      end
      // Set wins over a coincident clear.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fifo_wptr  <= '0;
      r_fifo_rptr  <= '0;
      r_fifo_count <= '0;
    end else if (flush) begin
      r_fifo_wptr  <= '0;
      r_fifo_rptr  <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_wptr <= r_fifo_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_fifo_rptr <= r_fifo_rptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + c_CNT_ONE;
        2'b01:   r_fifo_count <= r_fifo_count - c_CNT_ONE;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_fifo_wptr] <= bram_dout;
    end
  end

  assign m_tvalid        = w_fifo_nempty;
  assign m_tdata         = w_fifo_nempty ? r_fifo_mem[r_fifo_rptr] : 32'd0;
  assign bram_en         = r_bram_en;
  assign bram_addr       = r_bram_addr;
  assign bram_we         = 4'b0000;
  assign bram_clk        = clk;
  assign bram_rst        = ~rstn;
  assign read_address    = r_rd_ptr;
  assign words_available = r_words_avail;
  assign overrun         = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_bram_ring_reader.sv
// ============================================================================
// Module  : tb_bram_ring_reader
// Purpose : Directed scoreboard bench for bram_ring_reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bram_ring_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        clear_overrun = 1'b0;
  logic        m_tready = 1'b0;
  logic [13:0] write_address = 14'd0;
  logic [15:0] bram_addr;
  logic [31:0] bram_dout;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic        bram_clk;
  logic        bram_rst;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic [13:0] read_address;
  logic [14:0] words_available;
  logic        overrun;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // BRAM model: word i holds C0DE_0000 | i; garbage when no read is issued.
  assign bram_dout = bram_en ? (32'hC0DE_0000 | {18'd0, bram_addr[15:2]}) : 32'hDEAD_BEEF;

  bram_ring_reader dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable          (enable),
    .flush           (flush),
    .clear_overrun   (clear_overrun),
    .write_address   (write_address),
    .bram_addr       (bram_addr),
    .bram_dout       (bram_dout),
    .bram_en         (bram_en),
    .bram_we         (bram_we),
    .bram_clk        (bram_clk),
    .bram_rst        (bram_rst),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .read_address    (read_address),
    .words_available (words_available),
    .overrun         (overrun)
  );

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(word((first + i) % 16384));
  endtask

  task automatic monitor();
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = 32'd0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && m_tvalid) chk("hold_tdata", m_tdata, pd);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%08h, expected no beat", m_tdata);
          end else begin
            chk("beat", m_tdata, exp_q.pop_front());
          end
        end
        pv = m_tvalid;
        pr = m_tready;
        pd = m_tdata;
      end
    end
  endtask

  initial begin
    int  ens;
    int  beats;
    bit  done;
    logic [31:0] wrap_addr [4];

    fork
      monitor();
    join_none

    // Reset values
    #12;
    chk("rst_read_address", 32'(read_address), 32'd0);
    chk("rst_words_avail", 32'(words_available), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_bram_rst", 32'(bram_rst), 32'd1);

    // Basic 5-word transfer, latency and 1 word/clock
    step();
    rstn = 1'b1; enable = 1'b1; m_tready = 1'b1;
    step(); step();
    chk("bram_rst_released", 32'(bram_rst), 32'd0);
    write_address = 14'd5;
    push_words(0, 5);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t1_bram_en", 32'(bram_en), (k >= 2 && k <= 6) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 6) chk("t1_bram_addr", 32'(bram_addr), 32'((k - 2) * 4));
      chk("t1_tvalid", 32'(m_tvalid), (k >= 3 && k <= 7) ? 32'd1 : 32'd0);
    end
    step(); step(); step();
    chk("t1_read_address", 32'(read_address), 32'd5);
    chk("t1_words_avail", 32'(words_available), 32'd0);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with 3 words buffered and 1 read in flight
    m_tready = 1'b0;
    write_address = 14'd50;
    push_words(5, 45);
    ens = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bram_en) ens++;
      if (ens == 4) begin done = 1'b1; break; end
    end
    chk("fl_fourth_read_seen", 32'(done), 32'd1);
    chk("fl_tvalid_before", 32'(m_tvalid), 32'd1);
    chk("fl_head_before", m_tdata, word(5));
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    chk("fl_tvalid_after", 32'(m_tvalid), 32'd0);
    chk("fl_read_address", 32'(read_address), 32'd50);
    chk("fl_bram_en_after", 32'(bram_en), 32'd0);
    m_tready = 1'b1;
    ens = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bram_en) ens++;
    end
    chk("fl_no_reads", 32'(ens), 32'd0);

    // Wrap from 16382 to 2
    enable = 1'b0;
    write_address = 14'd16382;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("wr_read_address", 32'(read_address), 32'd16382);
    step();
    chk("wr_words_avail_zero", 32'(words_available), 32'd0);
    enable = 1'b1;
    step();
    wrap_addr[0] = 32'hFFF8; wrap_addr[1] = 32'hFFFC;
    wrap_addr[2] = 32'h0000; wrap_addr[3] = 32'h0004;
    write_address = 14'd2;
    exp_q.push_back(word(16382)); exp_q.push_back(word(16383));
    exp_q.push_back(word(0));     exp_q.push_back(word(1));
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("wr_bram_en", 32'(bram_en), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5) chk("wr_bram_addr", 32'(bram_addr), wrap_addr[k - 2]);
      if (k >= 2 && k <= 6) chk("wr_words_avail", 32'(words_available), 32'(6 - k));
    end
    step(); step(); step();
    chk("wr_read_address_end", 32'(read_address), 32'd2);
    chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wr_overrun", 32'(overrun), 32'd0);

    // Backpressure: 100 words pending
    m_tready = 1'b0;
    write_address = 14'd102;
    push_words(2, 100);
    ens = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bram_en) ens++;
    end
    chk("bp_reads_issued", 32'(ens), 32'd4);
    chk("bp_tvalid", 32'(m_tvalid), 32'd1);
    chk("bp_head", m_tdata, word(2));
    m_tready = 1'b1;
    beats = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_tvalid) beats++;
    end
    chk("bp_consecutive_beats", 32'(beats), 32'd100);
    @(negedge clk);
    chk("bp_tvalid_end", 32'(m_tvalid), 32'd0);
    step();
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_read_address", 32'(read_address), 32'd102);

    // Overrun threshold, sticky behaviour and clearing
    enable = 1'b0;
    write_address = 14'd0;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ov_read_address", 32'(read_address), 32'd0);
    chk("ov_start_clear", 32'(overrun), 32'd0);
    write_address = 14'd16367;
    step(); step(); step();
    chk("ov_below_threshold", 32'(overrun), 32'd0);
    write_address = 14'd16368;
    step();
    chk("ov_not_yet", 32'(overrun), 32'd0);
    step();
    chk("ov_set", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    chk("ov_sticky_under_gap", 32'(overrun), 32'd1);
    push_words(0, 16368);
    enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (words_available == 15'd0 && !m_tvalid && !bram_en) begin done = 1'b1; break; end
    end
    chk("ov_drained", 32'(done), 32'd1);
    chk("ov_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ov_still_set", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    chk("ov_cleared", 32'(overrun), 32'd0);
    chk("ov_read_address", 32'(read_address), 32'd16368);

    // Asynchronous reset mid-burst
    write_address = 14'd16352;
    push_words(16368, 40);
    for (int i = 0; i < 6; i++) step();
    chk("ar_tvalid_before", 32'(m_tvalid), 32'd1);
    chk("ar_bram_en_before", 32'(bram_en), 32'd1);
    chk("ar_overrun_before", 32'(overrun), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_tvalid", 32'(m_tvalid), 32'd0);
    chk("ar_bram_en", 32'(bram_en), 32'd0);
    chk("ar_overrun", 32'(overrun), 32'd0);
    chk("ar_tdata", m_tdata, 32'd0);
    chk("ar_read_address", 32'(read_address), 32'd0);
    exp_q.delete();
    write_address = 14'd0;
    step();
    rstn = 1'b1;
    beats = 0; ens = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_tvalid) beats++;
      if (bram_en) ens++;
    end
    chk("ar_no_stale_beats", 32'(beats), 32'd0);
    chk("ar_no_reads", 32'(ens), 32'd0);
    chk("ar_read_address_after", 32'(read_address), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_ring_reader.md
Name: bram_ring_reader

Overview:
- Drains the 32-bit word ring buffer that the acquisition path writes into BRAM. It presents the words in order on a valid/ready stream for the DMA/PS-facing logic.
- It tracks the writer's published word address, issues single-cycle BRAM reads with 1-cycle read latency, and buffers the results in a small prefetch FIFO so it can sustain one word per clock under backpressure.
- It flags overrun when the writer approaches the read pointer from behind.

Parameters:
- BRAM_DEPTH_WORDS, 16384: ring size in 32-bit words; any value from 2 to 16384; need not be a power of two.
- PREFETCH_DEPTH, 4: output FIFO entries; power of two, 2..16.
- OVERRUN_MARGIN, 16: when the occupancy gap reaches (BRAM_DEPTH_WORDS - OVERRUN_MARGIN) or more, overrun is raised.

Ports:
- clk  in  1  single clock for all logic and the BRAM port.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new BRAM reads are issued; reads already issued still complete; stream output continues draining.
- flush  in  1  one-cycle pulse; discards buffered data and sets the read pointer equal to the writer pointer.
- clear_overrun  in  1  one-cycle pulse; clears the sticky overrun flag.
- write_address  in  14  writer's next-write word address, in the range 0..BRAM_DEPTH_WORDS-1.
- bram_addr  out  16  byte address, equal to {rd_ptr, 2'b00}.
- bram_dout  in  32  BRAM read data; valid one cycle after bram_en.
- bram_en  out  1  read enable.
- bram_we  out  4  constant 0.
- bram_clk  out  1  equal to clk.
- bram_rst  out  1  equal to ~rstn.
- m_tdata  out  32  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- read_address  out  14  current rd_ptr, for PS monitoring.
- words_available  out  15  registered gap (wr_q - rd_ptr) mod BRAM_DEPTH_WORDS.
- overrun  out  1  sticky overrun flag.

Behaviour:
- Reset (async, rstn low) values:
  - rd_ptr=0, wr_q=0, words_available=0, bram_en=0, bram_addr=0.
  - Prefetch FIFO empty; m_tvalid=0, m_tdata=0; overrun=0; in-flight flag=0.
- Writer pointer capture:
  - write_address is registered into wr_q every cycle (1-cycle delay).
  - gap = wr_q - rd_ptr, plus BRAM_DEPTH_WORDS if the subtraction is negative. Compute it at 15 bits; no power-of-two assumption.
- Read issue: bram_en is registered. It is asserted on the next edge when all of these hold:
  - enable=1,
  - gap>0,
  - flush=0,
  - fifo_count + inflight < PREFETCH_DEPTH, where inflight counts a read issued in the previous cycle.
- On each issued read:
  - bram_addr <= {rd_ptr, 2'b00}.
  - rd_ptr advances by 1; it wraps to 0 after BRAM_DEPTH_WORDS-1.
  - gap is evaluated against the already-advanced rd_ptr, so back-to-back reads never overrun wr_q.
- Capture: in the cycle after bram_en=1, bram_dout is pushed into the prefetch FIFO.
- Stream output:
  - m_tvalid = FIFO non-empty; m_tdata = FIFO head.
  - A pop occurs on m_tvalid & m_tready.
  - m_tdata must hold stable while m_tvalid=1 and m_tready=0.
  - A push and a pop in the same cycle leave the count unchanged.
- Latency: write_address increments at edge E0 -> wr_q at E1 -> bram_en at E2 -> FIFO push at E3 -> m_tvalid=1 after E3, i.e. 3 cycles.
- Throughput: with m_tready held high, 1 word/clock sustained. Credit accounting must never overflow the FIFO.
- Flush:
  - rd_ptr <= wr_q; FIFO count <= 0; any in-flight read's data is dropped (not pushed).
  - bram_en=0 in the flush cycle; m_tvalid=0 on the following cycle.
  - flush takes precedence over every other event in the same cycle.
- Overrun:
  - Set when gap >= BRAM_DEPTH_WORDS - OVERRUN_MARGIN.
  - Stays set until clear_overrun is pulsed. If clear_overrun and the set condition occur in the same cycle, it remains set.
  - Reading continues normally; no data is dropped by this block.
- write_address values >= BRAM_DEPTH_WORDS are illegal inputs; behaviour is undefined but must not hang the FSM.
- Reset asserted mid-stream: all state clears immediately (async); outputs go to reset values with no partial beat.

Test Plan:
- Reset, then write_address 0 -> 5 with m_tready=1:
  - bram_en high for exactly 5 cycles starting 2 cycles after the change, bram_addr = 0x0, 0x4, ... 0x10.
  - Stream returns 5 words in order, first m_tvalid at +3 cycles.
  - read_address=5, words_available=0.
- Wrap, BRAM_DEPTH_WORDS=16384, rd_ptr=16382, write_address=2:
  - reads addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004 in that order.
  - words_available goes from 4 to 0.
- Backpressure: 100 words pending, m_tready=0:
  - exactly PREFETCH_DEPTH=4 reads are issued, then bram_en stays 0.
  - m_tdata stays stable.
  - Releasing m_tready delivers all 100 words in order, no duplicates or gaps, 1 word/clock.
- Flush pulse while 3 words are buffered and 1 read is in flight, write_address=50:
  - m_tvalid=0 next cycle; in-flight data discarded; read_address=50.
  - No BRAM read issued until write_address advances.
- Overrun with OVERRUN_MARGIN=16 and enable=0:
  - Advance write_address to 16368 -> overrun=1.
  - clear_overrun while the gap persists -> overrun stays 1.
  - After draining and clear_overrun -> overrun=0.
- Assert rstn low mid-burst:
  - m_tvalid, bram_en and overrun drop asynchronously.
  - After release, read_address=0 and no stale words appear on the stream.
